// File: rtl/bayer_window_5x5.sv
// bayer_window_5x5
//   Raster-to-window front end for CFA processing. Pixels arrive in raster
//   order, one per pix_valid cycle. Four line buffers plus a small column
//   shift register build a 5x5 neighbourhood. Every fully interior window
//   (centre at least two pixels from every edge) is presented for one cycle.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active high
//   pix_in     raster pixel, left->right, top->bottom
//   pix_valid  pixel valid; low = stall, nothing advances
//   sof        first pixel of frame (only sampled with pix_valid)
//   win_valid  window outputs valid this cycle
//   p_<r>_<c>  25 window pixels; r = row, c = column offset from centre
//   win_row    image row of the window centre
//   win_col    image column of the window centre
//   frame_done one-cycle pulse after the last pixel of a frame is accepted
module bayer_window_5x5 #(
   parameter int PIX_W = 12,
   parameter int IMG_W = 64,
   parameter int IMG_H = 64,
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PIX_W-1:0] pix_in,
   input  logic             pix_valid,
   input  logic             sof,
   output logic             win_valid,
   output logic [PIX_W-1:0] p_m2_m2, p_m2_m1, p_m2_p0, p_m2_p1, p_m2_p2,
   output logic [PIX_W-1:0] p_m1_m2, p_m1_m1, p_m1_p0, p_m1_p1, p_m1_p2,
   output logic [PIX_W-1:0] p_p0_m2, p_p0_m1, p_p0_p0, p_p0_p1, p_p0_p2,
   output logic [PIX_W-1:0] p_p1_m2, p_p1_m1, p_p1_p0, p_p1_p1, p_p1_p2,
   output logic [PIX_W-1:0] p_p2_m2, p_p2_m1, p_p2_p0, p_p2_p1, p_p2_p2,
   output logic [CNT_W-1:0] win_row,
   output logic [CNT_W-1:0] win_col,
   output logic             frame_done
);

   localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
   localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);
   localparam logic [CNT_W-1:0] FOUR     = CNT_W'(4);

   logic             accept;
   logic [CNT_W-1:0] col_q, row_q, col_d, row_d;
   logic [CNT_W-1:0] eff_col, eff_row;
   logic [AW-1:0]    wr_addr, rd_addr;
   logic             win_valid_d;

   logic [PIX_W-1:0] lb_rd   [4];   // LBk read data = pixel(row-1-k, col)
   logic [PIX_W-1:0] lb_wr   [4];
   logic [PIX_W-1:0] col_new [5];   // incoming p2 column, index 0 = row m2
   logic [PIX_W-1:0] sh_q    [4][5];// last four columns [col][row], 0 = oldest
   logic [PIX_W-1:0] win_q   [5][5];// presented window [row][col]
   logic [CNT_W-1:0] win_row_q, win_col_q;
   logic             win_valid_q, frame_done_q;

   assign accept  = pix_valid & ~rst;
   // sof forces the accepted pixel to (0,0), resynchronising mid-frame.
   assign eff_col = sof ? '0 : col_q;
   assign eff_row = sof ? '0 : row_q;

   always_comb begin
      col_d = eff_col + ONE;
      row_d = eff_row;
      if (eff_col == COL_LAST) begin
         col_d = '0;
         row_d = (eff_row == ROW_LAST) ? '0 : eff_row + ONE;
      end
   end

   // The RAM read is registered, so each accept prefetches the column the
   // next pixel will use. A resync via sof breaks the prefetch once, but the
   // wrong data only lands in entries standing for rows above the new frame,
   // which the validity gating never lets out.
   assign wr_addr = eff_col[AW-1:0];
   assign rd_addr = col_d[AW-1:0];

   assign win_valid_d = accept && (eff_row >= FOUR) && (eff_col >= FOUR);

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q <= '0;
         row_q <= '0;
      end else if (accept) begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   assign lb_wr[0] = pix_in;

   genvar gi;
   generate
      for (gi = 1; gi < 4; gi++) begin : g_chain
         assign lb_wr[gi] = lb_rd[gi-1];
      end

      for (gi = 0; gi < 4; gi++) begin : g_lb
         logic [PIX_W-1:0] mem [IMG_W];
         logic [PIX_W-1:0] rd_q;
         always_ff @(posedge clk) begin
            if (accept)
               mem[wr_addr] <= lb_wr[gi];
            if (rst)
               rd_q <= '0;
            else if (accept)
               rd_q <= mem[rd_addr];
         end
         assign lb_rd[gi]   = rd_q;
         assign col_new[gi] = lb_rd[3-gi];
      end
   endgenerate

   assign col_new[4] = pix_in;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 5; r++)
               sh_q[c][r] <= '0;
      end else if (accept) begin
         for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 3; c++)
               sh_q[c][r] <= sh_q[c+1][r];
            sh_q[3][r] <= col_new[r];
         end
      end
   end

   // Presented window only loads on an emitted window so it holds otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
               win_q[r][c] <= '0;
         win_row_q    <= '0;
         win_col_q    <= '0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         win_valid_q  <= win_valid_d;
         frame_done_q <= accept && (eff_row == ROW_LAST) && (eff_col == COL_LAST);
         if (win_valid_d) begin
            for (int r = 0; r < 5; r++) begin
               for (int c = 0; c < 4; c++)
                  win_q[r][c] <= sh_q[c][r];
               win_q[r][4] <= col_new[r];
            end
            win_row_q <= eff_row - TWO;
            win_col_q <= eff_col - TWO;
         end
      end
   end

   assign win_valid  = win_valid_q;
   assign frame_done = frame_done_q;
   assign win_row    = win_row_q;
   assign win_col    = win_col_q;

   assign p_m2_m2 = win_q[0][0];
   assign p_m2_m1 = win_q[0][1];
   assign p_m2_p0 = win_q[0][2];
   assign p_m2_p1 = win_q[0][3];
   assign p_m2_p2 = win_q[0][4];
   assign p_m1_m2 = win_q[1][0];
   assign p_m1_m1 = win_q[1][1];
   assign p_m1_p0 = win_q[1][2];
   assign p_m1_p1 = win_q[1][3];
   assign p_m1_p2 = win_q[1][4];
   assign p_p0_m2 = win_q[2][0];
   assign p_p0_m1 = win_q[2][1];
   assign p_p0_p0 = win_q[2][2];
   assign p_p0_p1 = win_q[2][3];
   assign p_p0_p2 = win_q[2][4];
   assign p_p1_m2 = win_q[3][0];
   assign p_p1_m1 = win_q[3][1];
   assign p_p1_p0 = win_q[3][2];
   assign p_p1_p1 = win_q[3][3];
   assign p_p1_p2 = win_q[3][4];
   assign p_p2_m2 = win_q[4][0];
   assign p_p2_m1 = win_q[4][1];
   assign p_p2_p0 = win_q[4][2];
   assign p_p2_p1 = win_q[4][3];
   assign p_p2_p2 = win_q[4][4];

endmodule

// File: tb/tb_bayer_window_5x5.sv
// Testbench for bayer_window_5x5 with an 8x8 image. A frame-level model keeps
// the current frame's pixels in an array and derives each expected window
// directly from image coordinates.
module tb_bayer_window_5x5;

   localparam int PIX_W = 12;
   localparam int IMG_W = 8;
   localparam int IMG_H = 8;
   localparam int CNT_W = 7;
   localparam int WINS_PER_FRAME = (IMG_W - 4) * (IMG_H - 4);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [PIX_W-1:0] pix_in = '0;
   logic             pix_valid = 1'b0;
   logic             sof = 1'b0;
   logic             win_valid, frame_done;
   logic [CNT_W-1:0] win_row, win_col;
   logic [PIX_W-1:0] p_m2_m2, p_m2_m1, p_m2_p0, p_m2_p1, p_m2_p2;
   logic [PIX_W-1:0] p_m1_m2, p_m1_m1, p_m1_p0, p_m1_p1, p_m1_p2;
   logic [PIX_W-1:0] p_p0_m2, p_p0_m1, p_p0_p0, p_p0_p1, p_p0_p2;
   logic [PIX_W-1:0] p_p1_m2, p_p1_m1, p_p1_p0, p_p1_p1, p_p1_p2;
   logic [PIX_W-1:0] p_p2_m2, p_p2_m1, p_p2_p0, p_p2_p1, p_p2_p2;
   logic [PIX_W-1:0] dut_p [5][5];

   always #5 clk = ~clk;

   bayer_window_5x5 #(
      .PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
      .win_valid(win_valid),
      .p_m2_m2(p_m2_m2), .p_m2_m1(p_m2_m1), .p_m2_p0(p_m2_p0), .p_m2_p1(p_m2_p1), .p_m2_p2(p_m2_p2),
      .p_m1_m2(p_m1_m2), .p_m1_m1(p_m1_m1), .p_m1_p0(p_m1_p0), .p_m1_p1(p_m1_p1), .p_m1_p2(p_m1_p2),
      .p_p0_m2(p_p0_m2), .p_p0_m1(p_p0_m1), .p_p0_p0(p_p0_p0), .p_p0_p1(p_p0_p1), .p_p0_p2(p_p0_p2),
      .p_p1_m2(p_p1_m2), .p_p1_m1(p_p1_m1), .p_p1_p0(p_p1_p0), .p_p1_p1(p_p1_p1), .p_p1_p2(p_p1_p2),
      .p_p2_m2(p_p2_m2), .p_p2_m1(p_p2_m1), .p_p2_p0(p_p2_p0), .p_p2_p1(p_p2_p1), .p_p2_p2(p_p2_p2),
      .win_row(win_row), .win_col(win_col), .frame_done(frame_done)
   );

   assign dut_p[0][0] = p_m2_m2; assign dut_p[0][1] = p_m2_m1; assign dut_p[0][2] = p_m2_p0;
   assign dut_p[0][3] = p_m2_p1; assign dut_p[0][4] = p_m2_p2;
   assign dut_p[1][0] = p_m1_m2; assign dut_p[1][1] = p_m1_m1; assign dut_p[1][2] = p_m1_p0;
   assign dut_p[1][3] = p_m1_p1; assign dut_p[1][4] = p_m1_p2;
   assign dut_p[2][0] = p_p0_m2; assign dut_p[2][1] = p_p0_m1; assign dut_p[2][2] = p_p0_p0;
   assign dut_p[2][3] = p_p0_p1; assign dut_p[2][4] = p_p0_p2;
   assign dut_p[3][0] = p_p1_m2; assign dut_p[3][1] = p_p1_m1; assign dut_p[3][2] = p_p1_p0;
   assign dut_p[3][3] = p_p1_p1; assign dut_p[3][4] = p_p1_p2;
   assign dut_p[4][0] = p_p2_m2; assign dut_p[4][1] = p_p2_m1; assign dut_p[4][2] = p_p2_p0;
   assign dut_p[4][3] = p_p2_p1; assign dut_p[4][4] = p_p2_p2;

   // Model state
   int n_cmp = 0;
   int n_bad = 0;
   int dut_wins = 0;
   int m_row = 0, m_col = 0;
   int img [IMG_H][IMG_W];
   int exp_p [5][5];
   int exp_row = 0, exp_col = 0, exp_wv = 0, exp_fd = 0;
   int cyc = 0;

   task automatic check_val(input string tag, input int obs, input int expv);
      n_cmp++;
      if (obs != expv) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic check_outputs();
      check_val("win_valid", int'(win_valid), exp_wv);
      check_val("frame_done", int'(frame_done), exp_fd);
      check_val("win_row", int'(win_row), exp_row);
      check_val("win_col", int'(win_col), exp_col);
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++)
            check_val($sformatf("p[%0d][%0d]", i, j), int'(dut_p[i][j]), exp_p[i][j]);
   endtask

   task automatic model_reset();
      m_row = 0; m_col = 0;
      exp_row = 0; exp_col = 0; exp_wv = 0; exp_fd = 0;
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++)
            exp_p[i][j] = 0;
      dut_wins = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; pix_valid = 1'b1; sof = 1'b0; pix_in = 12'hABC;
      model_reset();
      @(posedge clk); #1;
      check_outputs();
      $display("reset");
   endtask

   // One clock of stimulus followed by checking the registered outputs.
   task automatic step(input bit v, input bit s, input logic [PIX_W-1:0] px);
      int r, c;
      @(negedge clk);
      rst = 1'b0; pix_valid = v; sof = s; pix_in = px;
      exp_wv = 0; exp_fd = 0;
      if (v) begin
         r = s ? 0 : m_row;
         c = s ? 0 : m_col;
         img[r][c] = int'(px);
         if (r >= 4 && c >= 4) begin
            exp_wv = 1;
            for (int i = 0; i < 5; i++)
               for (int j = 0; j < 5; j++)
                  exp_p[i][j] = img[r-4+i][c-4+j];
            exp_row = r - 2;
            exp_col = c - 2;
         end
         if (c == IMG_W - 1) begin
            m_col = 0;
            if (r == IMG_H - 1) begin
               m_row = 0;
               exp_fd = 1;
            end else begin
               m_row = r + 1;
            end
         end else begin
            m_row = r;
            m_col = c + 1;
         end
      end
      @(posedge clk); #1;
      check_outputs();
      if (v && s) dut_wins = 0;
      if (win_valid) begin
         dut_wins++;
         $display("window centre=(%0d,%0d) p_p0_p0=%03h", win_row, win_col, p_p0_p0);
      end
      if (frame_done) begin
         check_val("wins_per_frame", dut_wins, WINS_PER_FRAME);
         $display("frame_done windows=%0d", dut_wins);
         dut_wins = 0;
      end
      cyc++;
   endtask

   // kind: 0 ramp, 1 random, 2 all 0xFFF, 3 ramp + 0x100
   // stall: 0 none, 1 every third cycle, 2 random
   task automatic run_frame(input int kind, input int stall, input int stop_r,
                            input int stop_c, input bit first_chk);
      logic [PIX_W-1:0] px;
      for (int r = 0; r < IMG_H; r++) begin
         for (int c = 0; c < IMG_W; c++) begin
            if (r == stop_r && c == stop_c) return;
            if ((stall == 1 && (cyc % 3) == 2) || (stall == 2 && $urandom_range(3) == 0))
               step(1'b0, 1'($urandom_range(1)), PIX_W'($urandom));
            case (kind)
               0:       px = PIX_W'(r * 16 + c);
               1:       px = PIX_W'($urandom);
               2:       px = 12'hFFF;
               default: px = PIX_W'(12'h100 + r * 16 + c);
            endcase
            step(1'b1, (r == 0 && c == 0), px);
            if (first_chk && r == 4 && c == 4) begin
               check_val("first_p_m2_m2", int'(p_m2_m2), 12'h000);
               check_val("first_p_p0_p0", int'(p_p0_p0), 12'h022);
               check_val("first_p_p2_p2", int'(p_p2_p2), 12'h044);
               check_val("first_p_m2_p2", int'(p_m2_p2), 12'h004);
               check_val("first_win_row", int'(win_row), 2);
               check_val("first_win_col", int'(win_col), 2);
            end
         end
      end
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      do_reset();
      step(1'b0, 1'b0, '0);
      run_frame(0, 0, -1, -1, 1'b1);      // plain ramp
      run_frame(0, 1, -1, -1, 1'b1);      // ramp with stalls every third cycle
      run_frame(0, 0, 5, 3, 1'b0);        // aborted by sof at (5,3)
      run_frame(3, 0, -1, -1, 1'b0);      // new frame data after resync
      run_frame(0, 0, 6, 6, 1'b0);        // interrupted by reset at (6,6)
      do_reset();
      run_frame(0, 0, -1, -1, 1'b1);      // restarted ramp
      run_frame(2, 0, -1, -1, 1'b0);      // two back-to-back saturated frames
      run_frame(2, 0, -1, -1, 1'b0);
      for (int k = 0; k < 3; k++)
         run_frame(1, 2, -1, -1, 1'b0);   // random data, random stalls
      repeat (3) step(1'b0, 1'b0, '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
